// File: rtl/axi_r_mux_n.sv
// axi_r_mux_n: N-slave to M-master AXI R channel mux with burst lock and 2-entry output FIFO.
// Define AXI_R_MUX_RR_EN for round-robin arbitration; otherwise the highest slave index wins.
module axi_r_mux_n #(
  parameter int NUM_SLAVES  = 3,
  parameter int NUM_MASTERS = 2,
  parameter int ID_BITS     = 4,
  parameter int MST_BITS    = 4,
  parameter int DATA_BITS   = 32,
  parameter int RESP_BITS   = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_SLAVES*(MST_BITS+ID_BITS)-1:0]  s_id_i,
  input  logic [NUM_SLAVES*DATA_BITS-1:0]           s_data_i,
  input  logic [NUM_SLAVES*RESP_BITS-1:0]           s_resp_i,
  input  logic [NUM_SLAVES-1:0]                     s_last_i,
  input  logic [NUM_SLAVES-1:0]                     s_valid_i,
  output logic [NUM_SLAVES-1:0]                     s_ready_o,
  output logic [NUM_MASTERS*ID_BITS-1:0]            m_id_o,
  output logic [NUM_MASTERS*DATA_BITS-1:0]          m_data_o,
  output logic [NUM_MASTERS*RESP_BITS-1:0]          m_resp_o,
  output logic [NUM_MASTERS-1:0]                    m_last_o,
  output logic [NUM_MASTERS-1:0]                    m_valid_o,
  input  logic [NUM_MASTERS-1:0]                    m_ready_i
);
  localparam int IDS = MST_BITS + ID_BITS;
  localparam int SW  = $clog2(NUM_SLAVES);
  localparam int W   = IDS + DATA_BITS + RESP_BITS + 1;
  typedef enum logic {IDLE, BURST} state_t;
  state_t state;
  logic [SW-1:0] lock_idx, win, gnt;
  logic win_vld, push, pop, head_ok;
  logic [W-1:0] mem [2];
  logic [W-1:0] din, head;
  logic [IDS-1:0] head_ids;
  logic [MST_BITS-1:0] head_mst;
  logic wr_ptr, rd_ptr;
  logic [1:0] cnt;
`ifdef AXI_R_MUX_RR_EN
  logic [SW-1:0] ptr;
  int j;
  // Scan downwards from the largest offset so the slave nearest the pointer wins.
  always_comb begin
    win = '0;
    win_vld = 1'b0;
    j = 0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      j = (j >= NUM_SLAVES) ? j - NUM_SLAVES : j;
      if (s_valid_i[j]) begin
        win = SW'(j);
        win_vld = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = '0;
    win_vld = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (s_valid_i[i]) begin
        win = SW'(i);
        win_vld = 1'b1;
      end
  end
`endif
  assign gnt = (state == BURST) ? lock_idx : win;
  assign s_ready_o = (rst && cnt < 2'd2 && (state == BURST || win_vld)) ? NUM_SLAVES'(1) << gnt : '0;
  assign push = |(s_valid_i & s_ready_o);
  assign din = {s_id_i[gnt*IDS +: IDS], s_data_i[gnt*DATA_BITS +: DATA_BITS],
                s_resp_i[gnt*RESP_BITS +: RESP_BITS], s_last_i[gnt]};
  assign head = mem[rd_ptr];
  assign head_ids = head[W-1 -: IDS];
  assign head_mst = head_ids[IDS-1:ID_BITS];
  assign head_ok = 32'(head_mst) < NUM_MASTERS;
  assign m_valid_o = (rst && cnt != 2'd0 && head_ok) ? NUM_MASTERS'(1) << head_mst : '0;
  // Heads addressed to a nonexistent master are discarded without waiting for any ready.
  assign pop = cnt != 2'd0 && (!head_ok || |(m_valid_o & m_ready_i));
  assign m_id_o = {NUM_MASTERS{head_ids[ID_BITS-1:0]}};
  assign m_data_o = {NUM_MASTERS{head[RESP_BITS+DATA_BITS:RESP_BITS+1]}};
  assign m_resp_o = {NUM_MASTERS{head[RESP_BITS:1]}};
  assign m_last_o = {NUM_MASTERS{head[0]}};
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      lock_idx <= '0;
      cnt <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
`ifdef AXI_R_MUX_RR_EN
      ptr <= '0;
`endif
    end else begin
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (pop) rd_ptr <= ~rd_ptr;
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= ~wr_ptr;
        state <= din[0] ? IDLE : BURST;
        lock_idx <= gnt;
`ifdef AXI_R_MUX_RR_EN
        if (din[0]) ptr <= (gnt == SW'(NUM_SLAVES - 1)) ? '0 : gnt + 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_axi_r_mux_n.sv
// tb_axi_r_mux_n: directed self-checking bench for axi_r_mux_n (default parameters).
module tb_axi_r_mux_n;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [23:0] s_id_i = '0;
  logic [95:0] s_data_i = '0;
  logic [5:0] s_resp_i = '0;
  logic [2:0] s_last_i = '0;
  logic [2:0] s_valid_i = '0;
  logic [2:0] s_ready_o;
  logic [7:0] m_id_o;
  logic [63:0] m_data_o;
  logic [3:0] m_resp_o;
  logic [1:0] m_last_o;
  logic [1:0] m_valid_o;
  logic [1:0] m_ready_i = 2'b11;
  int checks = 0;
  int errors = 0;
`ifdef AXI_R_MUX_RR_EN
  int gi [4] = '{0, 1, 2, 0};
`else
  int gi [4] = '{2, 2, 2, 2};
`endif
  axi_r_mux_n dut (
    .clk(clk), .rst(rst),
    .s_id_i(s_id_i), .s_data_i(s_data_i), .s_resp_i(s_resp_i), .s_last_i(s_last_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_id_o(m_id_o), .m_data_o(m_data_o), .m_resp_o(m_resp_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input int k, input logic v, input logic [7:0] id, input logic [31:0] d, input logic l);
    s_valid_i[k] = v;
    s_id_i[k*8 +: 8] = id;
    s_data_i[k*32 +: 32] = d;
    s_last_i[k] = l;
  endtask
  initial begin
    // reset forces handshakes low even with a valid slave
    drv(1, 1'b1, 8'h13, 32'hA1, 1'b1);
    cyc;
    cyc;
    chk("rst s_ready", 64'(s_ready_o), 64'h0);
    chk("rst m_valid", 64'(m_valid_o), 64'h0);
    // single beat
    rst = 1'b1;
    #1;
    chk("t1 s_ready", 64'(s_ready_o), 64'b010);
    cyc;
    drv(1, 1'b0, 8'h13, 32'hA1, 1'b1);
    #1;
    chk("t1 m_valid", 64'(m_valid_o), 64'b10);
    chk("t1 m_id", 64'(m_id_o), 64'h33);
    chk("t1 m_data", m_data_o, {32'hA1, 32'hA1});
    chk("t1 m_last", 64'(m_last_o), 64'b11);
    cyc;
    chk("t1 drained", 64'(m_valid_o), 64'h0);
    // burst lock
    drv(0, 1'b1, 8'h05, 32'h100, 1'b0);
    #1;
    chk("t2 idle grant s0", 64'(s_ready_o), 64'b001);
    cyc;
    drv(0, 1'b1, 8'h05, 32'h101, 1'b0);
    drv(2, 1'b1, 8'h16, 32'h200, 1'b1);
    #1;
    chk("t2 beat2 lock", 64'(s_ready_o), 64'b001);
    chk("t2 beat1 out", m_data_o, {2{32'h100}});
    chk("t2 beat1 valid", 64'(m_valid_o), 64'b01);
    cyc;
    drv(0, 1'b1, 8'h05, 32'h102, 1'b0);
    #1;
    chk("t2 beat3 lock", 64'(s_ready_o), 64'b001);
    chk("t2 beat2 out", m_data_o, {2{32'h101}});
    cyc;
    drv(0, 1'b1, 8'h05, 32'h103, 1'b1);
    #1;
    chk("t2 beat4 lock", 64'(s_ready_o), 64'b001);
    cyc;
    drv(0, 1'b0, 8'h05, 32'h103, 1'b1);
    #1;
    chk("t2 s2 granted", 64'(s_ready_o), 64'b100);
    chk("t2 beat4 out", m_data_o, {2{32'h103}});
    chk("t2 beat4 last", 64'(m_last_o), 64'b11);
    cyc;
    drv(2, 1'b0, 8'h16, 32'h200, 1'b1);
    #1;
    chk("t2 s2 valid", 64'(m_valid_o), 64'b10);
    chk("t2 s2 data", m_data_o, {2{32'h200}});
    cyc;
    chk("t2 drained", 64'(m_valid_o), 64'h0);
    // arbitration order with all slaves offering single-beat bursts
    for (int k = 0; k < 3; k++) drv(k, 1'b1, 8'(k), 32'h10 + 32'(k), 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t3 grant%0d", i), 64'(s_ready_o), 64'(3'b001 << gi[i]));
      if (i > 0) begin
        chk($sformatf("t3 valid%0d", i), 64'(m_valid_o), 64'b01);
        chk($sformatf("t3 id%0d", i), 64'(m_id_o), 64'({2{4'(gi[i-1])}}));
      end
      cyc;
    end
    for (int k = 0; k < 3; k++) drv(k, 1'b0, 8'(k), 32'h10 + 32'(k), 1'b1);
    #1;
    chk("t3 last id", 64'(m_id_o), 64'({2{4'(gi[3])}}));
    cyc;
    chk("t3 drained", 64'(m_valid_o), 64'h0);
    // backpressure on master 0
    m_ready_i = 2'b10;
    drv(1, 1'b1, 8'h07, 32'h300, 1'b0);
    #1;
    chk("t4 grant s1", 64'(s_ready_o), 64'b010);
    cyc;
    drv(1, 1'b1, 8'h07, 32'h301, 1'b0);
    #1;
    chk("t4 one entry ready", 64'(s_ready_o), 64'b010);
    chk("t4 head held", m_data_o, {2{32'h300}});
    cyc;
    drv(1, 1'b1, 8'h07, 32'h302, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t4 full%0d", i), 64'(s_ready_o), 64'b000);
      chk($sformatf("t4 stable%0d", i), m_data_o, {2{32'h300}});
      chk($sformatf("t4 valid%0d", i), 64'(m_valid_o), 64'b01);
      cyc;
    end
    m_ready_i = 2'b11;
    #1;
    chk("t4 still full", 64'(s_ready_o), 64'b000);
    cyc;
    chk("t4 after pop ready", 64'(s_ready_o), 64'b010);
    chk("t4 order 301", m_data_o, {2{32'h301}});
    cyc;
    drv(1, 1'b1, 8'h07, 32'h303, 1'b1);
    #1;
    chk("t4 order 302", m_data_o, {2{32'h302}});
    cyc;
    drv(1, 1'b0, 8'h07, 32'h303, 1'b1);
    #1;
    chk("t4 order 303", m_data_o, {2{32'h303}});
    chk("t4 last", 64'(m_last_o), 64'b11);
    cyc;
    chk("t4 drained", 64'(m_valid_o), 64'h0);
    // decode error: master index 5 is dropped without any ready
    m_ready_i = 2'b00;
    drv(2, 1'b1, 8'h51, 32'h400, 1'b1);
    #1;
    chk("t5 grant s2", 64'(s_ready_o), 64'b100);
    cyc;
    drv(2, 1'b1, 8'h02, 32'h401, 1'b1);
    #1;
    chk("t5 bad head no valid", 64'(m_valid_o), 64'b00);
    cyc;
    drv(2, 1'b0, 8'h02, 32'h401, 1'b1);
    #1;
    chk("t5 next valid", 64'(m_valid_o), 64'b01);
    chk("t5 next data", m_data_o, {2{32'h401}});
    chk("t5 next id", 64'(m_id_o), 64'h22);
    m_ready_i = 2'b11;
    cyc;
    chk("t5 drained", 64'(m_valid_o), 64'h0);
    // reset in the middle of a burst
    m_ready_i = 2'b00;
    drv(0, 1'b1, 8'h09, 32'h500, 1'b0);
    #1;
    chk("t6 grant s0", 64'(s_ready_o), 64'b001);
    cyc;
    drv(0, 1'b1, 8'h09, 32'h501, 1'b0);
    rst = 1'b0;
    #1;
    chk("t6 rst s_ready", 64'(s_ready_o), 64'b000);
    chk("t6 rst m_valid", 64'(m_valid_o), 64'b00);
    cyc;
    rst = 1'b1;
    drv(0, 1'b0, 8'h09, 32'h501, 1'b0);
    drv(1, 1'b1, 8'h1A, 32'h600, 1'b1);
    #1;
    chk("t6 fifo flushed", 64'(m_valid_o), 64'b00);
    chk("t6 new grant", 64'(s_ready_o), 64'b010);
    cyc;
    drv(1, 1'b0, 8'h1A, 32'h600, 1'b1);
    m_ready_i = 2'b11;
    #1;
    chk("t6 new valid", 64'(m_valid_o), 64'b10);
    chk("t6 new data", m_data_o, {2{32'h600}});
    chk("t6 new id", 64'(m_id_o), 64'hAA);
    cyc;
    chk("t6 drained", 64'(m_valid_o), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
